// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scanner. Drives one column low at a time,
// debounces the row pattern on that column, emits a 4-bit key code over
// valid/ready and waits for a debounced release before scanning resumes.
// Optional feature: define KEYPAD_REPEAT_EN for auto-repeat while a key is held.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 27000,
  parameter int unsigned DB_CYCLES     = 540000,
  parameter int unsigned REPEAT_CYCLES = 13500000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_busy
);

  typedef enum logic [2:0] {
    S_SETTLE,
    S_SAMPLE,
    S_CONFIRM,
    S_EMIT,
    S_RELEASE
  } state_e;

  localparam logic [23:0] SETTLE_LAST = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] DB_LAST     = 24'(DB_CYCLES - 1);

  // Active-low column drive for a given column index.
  function automatic logic [3:0] col_onehot(input logic [1:0] idx);
    col_onehot = ~(4'b0001 << idx);
  endfunction

  // Index of the lowest 0 bit of a row pattern.
  function automatic logic [1:0] low_idx(input logic [3:0] p);
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!p[i]) low_idx = 2'(i);
    end
  endfunction

  // True when exactly one row line is pulled low.
  function automatic logic single_low(input logic [3:0] p);
    single_low = ($countones(~p) == 1);
  endfunction

  logic [3:0]  sync1_q;
  logic [3:0]  rows_s_q;
  state_e      state_q;
  logic [23:0] cnt_q;
  logic [1:0]  col_idx_q;
  logic [3:0]  col_n_q;
  logic [3:0]  pat_q;
  logic [3:0]  key_code_q;
  logic        key_valid_q;
  logic        key_busy_q;
`ifdef KEYPAD_REPEAT_EN
  localparam logic [23:0] REP_LAST = 24'(REPEAT_CYCLES - 1);
  logic [23:0] rep_q;
`endif

  // Two-flop synchronizer for the asynchronous row lines; idle value is all-high.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      sync1_q  <= 4'hF;
      rows_s_q <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make both flops sample the old values, giving a true 2-stage chain.
      sync1_q  <= row_n;
      rows_s_q <= sync1_q;
    end
  end

  // Scan / debounce / emit / release state machine with registered outputs.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_SETTLE;
      cnt_q       <= '0;
      col_idx_q   <= 2'd0;
      col_n_q     <= 4'b1110;
      pat_q       <= 4'hF;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_busy_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= '0;
            state_q <= S_SAMPLE;
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        S_SAMPLE: begin
          cnt_q <= '0;
          if (rows_s_q == 4'hF) begin
            col_idx_q <= col_idx_q + 2'd1;
            col_n_q   <= col_onehot(col_idx_q + 2'd1);
            state_q   <= S_SETTLE;
          end else begin
            pat_q   <= rows_s_q;
            state_q <= S_CONFIRM;
          end
        end

        S_CONFIRM: begin
          if (rows_s_q != pat_q) begin
            // Bounce: restart settling on the same column.
            cnt_q   <= '0;
            state_q <= S_SETTLE;
          end else if (cnt_q == DB_LAST) begin
            cnt_q      <= '0;
            key_busy_q <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
            rep_q      <= '0;
`endif
            if (single_low(pat_q)) begin
              key_valid_q <= 1'b1;
              key_code_q  <= {low_idx(pat_q), col_idx_q};
              state_q     <= S_EMIT;
            end else begin
              // Multi-key or ghost pattern: swallow it and wait for release.
              state_q <= S_RELEASE;
            end
          end else begin
            cnt_q <= cnt_q + 24'd1;
          end
        end

        S_EMIT: begin
          // Rows are ignored here; a confirmed press is always delivered.
          if (key_ready) begin
            key_valid_q <= 1'b0;
            cnt_q       <= '0;
            state_q     <= S_RELEASE;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
          end
        end

        S_RELEASE: begin
          if (rows_s_q == 4'hF) begin
            if (cnt_q == DB_LAST) begin
              cnt_q      <= '0;
              col_idx_q  <= col_idx_q + 2'd1;
              col_n_q    <= col_onehot(col_idx_q + 2'd1);
              key_busy_q <= 1'b0;
              state_q    <= S_SETTLE;
            end else begin
              cnt_q <= cnt_q + 24'd1;
            end
          end else begin
            cnt_q <= '0;
          end
`ifdef KEYPAD_REPEAT_EN
          // Held key (same single-key pattern) re-emits the latched code.
          if (rows_s_q == pat_q && single_low(pat_q)) begin
            if (rep_q == REP_LAST) begin
              rep_q       <= '0;
              cnt_q       <= '0;
              key_valid_q <= 1'b1;
              state_q     <= S_EMIT;
            end else begin
              rep_q <= rep_q + 24'd1;
            end
          end else begin
            rep_q <= '0;
          end
`endif
        end

        default: state_q <= S_SETTLE;
      endcase
    end
  end

  assign col_n     = col_n_q;
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_busy  = key_busy_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed testbench for keypad_scan_ctrl with SETTLE=4, DB=8, REPEAT=32.
// A behavioural keypad pulls a row low while its pressed key's column is driven.
module tb_keypad_scan_ctrl;

  logic       clk;
  logic       n_reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_busy;

  logic [15:0] keys;    // bit r*4+c = key at row r, column c pressed
  logic        bounce;  // forces all rows high (contact bounce)
  int          cyc;
  int          n_checks;
  int          n_fail;

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(4),
    .DB_CYCLES    (8),
    .REPEAT_CYCLES(32)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .key_busy (key_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model.
  always_comb begin
    row_n = 4'hF;
    if (!bounce) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          if (keys[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  // Leaves the DUT just out of reset at a falling edge; that cycle is cycle 0.
  task automatic reset_dut();
    n_reset   = 1'b0;
    keys      = 16'h0;
    bounce    = 1'b0;
    key_ready = 1'b1;
    repeat (3) @(negedge clk);
    n_reset = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    n_reset   = 1'b0;
    keys      = 16'h0;
    bounce    = 1'b0;
    key_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (col_n !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'h0 || key_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: col_n=%b valid=%b code=%h busy=%b, required 1110 0 0 0",
               col_n, key_valid, key_code, key_busy);
    end
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp_col;
    reset_dut();
    for (int k = 0; k <= 20; k++) begin
      if (k > 0) step();
      exp_col = ~(4'b0001 << ((k / 5) % 4));
      n_checks++;
      if (col_n !== exp_col || key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_scan cyc %0d: col_n=%b valid=%b, required col_n=%b valid=0",
                 cyc, col_n, key_valid, exp_col);
      end
    end
  endtask

  task automatic test_single_key();
    reset_dut();
    keys[9] = 1'b1;  // row 2, column 1
    while (cyc < 17) begin
      step();
      n_checks++;
      if (key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_early cyc %0d: valid=%b, required 0", cyc, key_valid);
      end
    end
    step();  // cycle 18: SAMPLE at 9 + DB + 1
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9 || key_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_emit: valid=%b code=%h busy=%b, required 1 9 1", key_valid, key_code, key_busy);
    end
    step();  // cycle 19: handshake taken
    n_checks++;
    if (key_valid !== 1'b0 || key_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_after_hs: valid=%b busy=%b, required 0 1", key_valid, key_busy);
    end
    step();  // cycle 20
    keys = 16'h0;
    while (cyc < 29) step();
    n_checks++;
    if (col_n !== 4'b1101 || key_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_release_hold: col_n=%b busy=%b, required 1101 1", col_n, key_busy);
    end
    step();  // cycle 30
    n_checks++;
    if (col_n !== 4'b1011 || key_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release_done: col_n=%b busy=%b, required 1011 0", col_n, key_busy);
    end
  endtask

  task automatic test_bounce();
    reset_dut();
    keys[9] = 1'b1;
    while (cyc < 26) begin
      step();
      if (cyc == 11) bounce = 1'b1;
      if (cyc == 13) bounce = 1'b0;
      n_checks++;
      if (key_valid !== 1'b0 || col_n !== ((cyc < 5) ? 4'b1110 : 4'b1101)) begin
        n_fail++;
        $display("FAIL bounce_hold cyc %0d: valid=%b col_n=%b, required valid=0", cyc, key_valid, col_n);
      end
    end
    step();  // cycle 27: re-SAMPLE at 18 + DB + 1
    n_checks++;
    if (key_valid !== 1'b1 || key_code !== 4'h9) begin
      n_fail++;
      $display("FAIL bounce_emit: valid=%b code=%h, required 1 9", key_valid, key_code);
    end
  endtask

  task automatic test_ready_hold();
    reset_dut();
    keys[9]   = 1'b1;
    key_ready = 1'b0;
    while (cyc < 17) step();
    while (cyc < 37) begin
      step();
      n_checks++;
      if (key_valid !== 1'b1 || key_code !== 4'h9) begin
        n_fail++;
        $display("FAIL ready_hold cyc %0d: valid=%b code=%h, required 1 9", cyc, key_valid, key_code);
      end
      if (cyc == 20) keys = 16'h0;
    end
    key_ready = 1'b1;
    while (cyc < 70) begin
      step();
      n_checks++;
      if (key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ready_no_dup cyc %0d: valid=%b, required 0", cyc, key_valid);
      end
      if (cyc == 45 || cyc == 46) begin
        n_checks++;
        if (col_n !== ((cyc == 45) ? 4'b1101 : 4'b1011) || key_busy !== (cyc == 45)) begin
          n_fail++;
          $display("FAIL ready_release cyc %0d: col_n=%b busy=%b", cyc, col_n, key_busy);
        end
      end
    end
  endtask

  task automatic test_ghost();
    reset_dut();
    keys[2]  = 1'b1;  // row 0, column 2
    keys[14] = 1'b1;  // row 3, column 2
    while (cyc < 50) begin
      step();
      if (cyc == 40) keys = 16'h0;
      n_checks++;
      if (key_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ghost_no_emit cyc %0d: valid=%b, required 0", cyc, key_valid);
      end
      if (cyc >= 10 && cyc <= 49 && col_n !== 4'b1011) begin
        n_checks++;
        n_fail++;
        $display("FAIL ghost_col_hold cyc %0d: col_n=%b, required 1011", cyc, col_n);
      end
      if (cyc == 22 || cyc == 23) begin
        n_checks++;
        if (key_busy !== (cyc == 23)) begin
          n_fail++;
          $display("FAIL ghost_busy cyc %0d: busy=%b", cyc, key_busy);
        end
      end
    end
    n_checks++;
    if (col_n !== 4'b0111 || key_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ghost_release: col_n=%b busy=%b, required 0111 0", col_n, key_busy);
    end
  endtask

  task automatic test_repeat();
    int emits;
    int first;
    reset_dut();
    keys[9] = 1'b1;
    emits   = 0;
    first   = -1;
    while (cyc < 18) step();
    n_checks++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_first: valid=%b, required 1", key_valid);
    end
    while (cyc < 118) begin
      step();
      if (key_valid === 1'b1) begin
        emits++;
        if (first < 0) first = cyc;
      end
    end
    n_checks++;
`ifdef KEYPAD_REPEAT_EN
    if (emits != 3 || first != 51) begin
      n_fail++;
      $display("FAIL repeat_count: emits=%0d first=%0d, required 3 at 51", emits, first);
    end
`else
    if (emits != 0) begin
      n_fail++;
      $display("FAIL repeat_count: extra emits=%0d, required 0", emits);
    end
`endif
  endtask

  task automatic test_reset_mid();
    reset_dut();
    keys[9]   = 1'b1;
    key_ready = 1'b0;
    while (cyc < 18) step();
    n_checks++;
    if (key_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_pre: valid=%b, required 1", key_valid);
    end
    #2 n_reset = 1'b0;
    #1;
    n_checks++;
    if (key_valid !== 1'b0 || key_busy !== 1'b0 || col_n !== 4'b1110 || key_code !== 4'h0) begin
      n_fail++;
      $display("FAIL midreset_async: valid=%b busy=%b col_n=%b code=%h, required 0 0 1110 0",
               key_valid, key_busy, col_n, key_code);
    end
    @(negedge clk);
    n_reset = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    test_reset();
    test_idle_scan();
    test_single_key();
    test_bounce();
    test_ready_hold();
    test_ghost();
    test_repeat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
